// File: rtl/it_svc_pkg.sv
// Shared types, default parameter values and constant helpers for the
// it_svc interrupt service block.
package it_svc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PEND     = 3'd1,
    CLR      = 3'd2,
    WAIT_LOW = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_CLR_LEN = 2;
  localparam int DEF_TMO     = 16;
  localparam int DEF_HOLDOFF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/it_svc_dn_timer.sv
// Loadable down-counter; zero is high while the count is 0.
import it_svc_pkg::*;

module dn_timer #(
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [w-1:0] load_val,
  output logic         zero
);

  logic [w-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - w'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/it_svc.sv
// Consumer-side service FSM for the counter interrupt flag.
// Optional build macro: IT_SVC_AUTO_ACK_EN (PEND lasts one cycle, ack ignored).
import it_svc_pkg::*;

module it_svc #(
  parameter int width   = DEF_WIDTH,
  parameter int clr_len = DEF_CLR_LEN,
  parameter int tmo     = DEF_TMO,
  parameter int holdoff = DEF_HOLDOFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             it,
  input  logic             ack,
  input  logic             ev_clr,
  output logic             irq,
  output logic             clr_it,
  output logic             busy,
  output logic [width-1:0] events,
  output logic             stuck
);

  localparam int TW_RAW = clog2(max3(clr_len, tmo, holdoff) + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] CLR_LD  = TW'(clr_len - 1);
  localparam logic [TW-1:0] TMO_LD  = TW'(tmo - 1);
  localparam logic [TW-1:0] HOLD_LD = (holdoff > 0) ? TW'(holdoff - 1) : '0;

  state_t        state, state_nxt;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          ev_inc, stuck_set, go_clr;

`ifdef IT_SVC_AUTO_ACK_EN
  logic unused_ack;
  assign unused_ack = ack;
  assign go_clr = 1'b1;
`else
  assign go_clr = ack;
`endif

  dn_timer #(.w(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    ev_inc    = 1'b0;
    stuck_set = 1'b0;
    case (state)
      IDLE: begin
        if (en && it) state_nxt = PEND;
      end
      PEND: begin
        if (go_clr) begin
          state_nxt = CLR;
          tmr_load  = 1'b1;
          tmr_val   = CLR_LD;
          ev_inc    = 1'b1;
        end
      end
      CLR: begin
        if (tmr_zero) begin
          state_nxt = WAIT_LOW;
          tmr_load  = 1'b1;
          tmr_val   = TMO_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!it || tmr_zero) begin
          stuck_set = it;
          if (holdoff == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LD;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLD: begin
        if (tmr_zero) state_nxt = IDLE;
        else          tmr_dec   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      irq    <= 1'b0;
      clr_it <= 1'b0;
      busy   <= 1'b0;
      events <= '0;
      stuck  <= 1'b0;
    end else begin
      state  <= state_nxt;
      irq    <= (state_nxt == PEND);
      clr_it <= (state_nxt == CLR);
      busy   <= (state_nxt != IDLE);
      if (ev_clr)      events <= '0;
      else if (ev_inc) events <= events + width'(1);
      if (stuck_set)   stuck <= 1'b1;
      else if (ev_clr) stuck <= 1'b0;
    end
  end

endmodule

// File: tb/tb_it_svc.sv
// Directed self-checking bench for it_svc with default parameters.
module tb_it_svc;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, it = 1'b0, ack = 1'b0, ev_clr = 1'b0;
  logic irq, clr_it, busy, stuck;
  logic [3:0] events;
  logic [3:0] exp_ev;
  int n_chk = 0;
  int n_pass = 0;

  it_svc dut (
    .clk(clk), .rst(rst), .en(en), .it(it), .ack(ack), .ev_clr(ev_clr),
    .irq(irq), .clr_it(clr_it), .busy(busy), .events(events), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, it, ack, evc;
    logic       irq, clr, busy;
    logic [3:0] ev;
    logic       stk;
  } vec_t;

  vec_t vecs [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Step until busy drops; counts further clr_it cycles.
  task automatic wait_idle(input int clr_seen, input string name);
    int  nclr;
    logic done;
    nclr = clr_seen;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      step();
      if (clr_it) nclr = nclr + 1;
      if (!busy) done = 1'b1;
    end
    chk({name, ".idle"}, {31'd0, done}, 32'd1);
    chk({name, ".clr_len"}, nclr, 32'd2);
  endtask

  task automatic service(input int dly);
    en = 1'b1; it = 1'b1; ack = 1'b0;
    step();
    chk("svc.irq_pend", {31'd0, irq}, 32'd1);
    for (int i = 1; i < dly; i++) begin
      step();
      chk("svc.irq_hold", {31'd0, irq}, 32'd1);
      chk("svc.no_clr", {31'd0, clr_it}, 32'd0);
    end
    ack = 1'b1;
    step();
    exp_ev = exp_ev + 4'd1;
    chk("svc.clr_on", {31'd0, clr_it}, 32'd1);
    chk("svc.irq_off", {31'd0, irq}, 32'd0);
    chk("svc.events", {28'd0, events}, {28'd0, exp_ev});
    ack = 1'b0; it = 1'b0;
    wait_idle(1, "svc");
  endtask

  initial begin
    //          rst  en    it    ack   evc   irq   clr   busy  ev     stuck
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};

`ifndef IT_SVC_AUTO_ACK_EN
    for (int v = 0; v < 22; v++) begin
      rst = vecs[v].rst; en = vecs[v].en; it = vecs[v].it;
      ack = vecs[v].ack; ev_clr = vecs[v].evc;
      step();
      chk($sformatf("vec%0d.irq", v), {31'd0, irq}, {31'd0, vecs[v].irq});
      chk($sformatf("vec%0d.clr_it", v), {31'd0, clr_it}, {31'd0, vecs[v].clr});
      chk($sformatf("vec%0d.busy", v), {31'd0, busy}, {31'd0, vecs[v].busy});
      chk($sformatf("vec%0d.events", v), {28'd0, events}, {28'd0, vecs[v].ev});
      chk($sformatf("vec%0d.stuck", v), {31'd0, stuck}, {31'd0, vecs[v].stk});
    end
`endif

    // Reset while clr_it is active.
    rst = 1'b1; en = 1'b0; it = 1'b0; ack = 1'b0; ev_clr = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; it = 1'b1; ack = 1'b1;
    step();
    step();
    chk("rstclr.clr_before", {31'd0, clr_it}, 32'd1);
    chk("rstclr.ev_before", {28'd0, events}, 32'd1);
    rst = 1'b1;
    step();
    chk("rstclr.clr_it", {31'd0, clr_it}, 32'd0);
    chk("rstclr.events", {28'd0, events}, 32'd0);
    chk("rstclr.busy", {31'd0, busy}, 32'd0);
    chk("rstclr.irq", {31'd0, irq}, 32'd0);
    rst = 1'b0; it = 1'b0; ack = 1'b0;
    step();
    chk("rstclr.idle", {31'd0, busy}, 32'd0);
    exp_ev = 4'd0;

`ifdef IT_SVC_AUTO_ACK_EN
    for (int s = 0; s < 4; s++) begin
      en = 1'b1; it = 1'b1; ack = 1'b0;
      step();
      chk("auto.irq", {31'd0, irq}, 32'd1);
      chk("auto.no_clr", {31'd0, clr_it}, 32'd0);
      step();
      exp_ev = exp_ev + 4'd1;
      chk("auto.irq_pulse", {31'd0, irq}, 32'd0);
      chk("auto.clr", {31'd0, clr_it}, 32'd1);
      chk("auto.events", {28'd0, events}, {28'd0, exp_ev});
      it = 1'b0;
      wait_idle(1, "auto");
    end
`else
    service(1);
    for (int s = 0; s < 16; s++) service(10);
    chk("wrap.events", {28'd0, events}, 32'd1);

    // it held high forever: timeout sets stuck, then re-entry.
    en = 1'b1; it = 1'b1; ack = 1'b1;
    step();
    step();
    exp_ev = exp_ev + 4'd1;
    ack = 1'b0;
    step();
    step();
    chk("stk.wait_low", {31'd0, clr_it}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("stk.early", {31'd0, stuck}, 32'd0);
      chk("stk.busy", {31'd0, busy}, 32'd1);
    end
    step();
    chk("stk.set", {31'd0, stuck}, 32'd1);
    chk("stk.hold", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stk.hold_busy", {31'd0, busy}, 32'd1);
    end
    step();
    chk("stk.idle", {31'd0, busy}, 32'd0);
    chk("stk.idle_irq", {31'd0, irq}, 32'd0);
    chk("stk.sticky", {31'd0, stuck}, 32'd1);
    step();
    chk("stk.repend", {31'd0, irq}, 32'd1);
    ev_clr = 1'b1;
    step();
    exp_ev = 4'd0;
    ev_clr = 1'b0;
    chk("stk.cleared", {31'd0, stuck}, 32'd0);
    chk("stk.ev_cleared", {28'd0, events}, 32'd0);
    chk("stk.still_pend", {31'd0, irq}, 32'd1);
    ack = 1'b1; it = 1'b0;
    step();
    exp_ev = exp_ev + 4'd1;
    chk("stk.final_ev", {28'd0, events}, {28'd0, exp_ev});
    ack = 1'b0;
    wait_idle(1, "stk");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
